// File: rtl/datasink_ram_if.sv
// Stream handshake bundle between the ROM-driven source and the capture sink.
// The master drives the word and its valid flag; the slave answers with ready.
interface datasink_ram_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/datasink_ram.sv
// Stream sink that captures DEPTH words into a RAM, counts and sums them, and
// flags done when full. A registered random-access port reads the RAM back.
module datasink_ram #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int THROTTLE = 0
) (
  input  logic                clk,
  input  logic                reset,
  datasink_ram_if.slave       s_axis,
  input  logic                clear,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                done,
  output logic [ADDR_W:0]     wr_count,
  output logic [31:0]         checksum
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic [31:0]         checksum_q, checksum_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                xfer;
  logic [DATA_W-1:0]   mem [DEPTH];

  function automatic logic [31:0] sum_wrap(input logic [31:0] acc,
                                           input logic [DATA_W-1:0] word);
    return acc + 32'(word);
  endfunction

  // clear masks tready in its own cycle so a word is never accepted and then discarded
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    wr_addr_d     = wr_addr_q;
    wr_count_d    = wr_count_q;
    checksum_d    = checksum_q;
    s_axis.tready = 1'b0;
    if (state_q == ST_FILL)
      s_axis.tready = !clear && ((THROTTLE == 0) || !phase_q);
    xfer = s_axis.tready && s_axis.tvalid;

    if (clear) begin
      state_d    = ST_IDLE;
      phase_d    = 1'b0;
      wr_addr_d  = '0;
      wr_count_d = '0;
      checksum_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          phase_d = 1'b0;
        end
        ST_FILL: begin
          phase_d = !phase_q;
          if (xfer) begin
            wr_addr_d  = wr_addr_q + 1'b1;
            wr_count_d = wr_count_q + 1'b1;
            checksum_d = sum_wrap(checksum_q, s_axis.tdata);
            if (wr_count_q == LAST_CNT)
              state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Stage boundary: control and readback registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_count_q <= '0;
      checksum_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_addr_q  <= wr_addr_d;
      wr_count_q <= wr_count_d;
      checksum_q <= checksum_d;
      rd_data_q  <= mem[rd_addr];
    end
  end

  // RAM is never reset; captured words survive clear and reset
  always_ff @(posedge clk) begin
    if (xfer)
      mem[wr_addr_q] <= s_axis.tdata;
  end

  assign rd_data  = rd_data_q;
  assign done     = (state_q == ST_DONE);
  assign wr_count = wr_count_q;
  assign checksum = checksum_q;
endmodule

// File: tb/tb_datasink_ram.sv
// Drives one THROTTLE=0 and one THROTTLE=1 sink with the same stimulus and
// checks both against a word-level model, plus directed scenario checks.
module tb_datasink_ram;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          tv    = 1'b0;
  logic [DW-1:0] td    = '0;
  logic [AW-1:0] ra    = '0;
  logic          tr [2];
  logic [DW-1:0] rd [2];
  logic          dn [2];
  logic [AW:0]   cnt [2];
  logic [31:0]   cs [2];

  int unsigned total = 0;
  int unsigned bad   = 0;

  datasink_ram_if #(.DATA_W(DW)) ax0 ();
  datasink_ram_if #(.DATA_W(DW)) ax1 ();
  assign ax0.tvalid = tv;
  assign ax0.tdata  = td;
  assign ax1.tvalid = tv;
  assign ax1.tdata  = td;
  assign tr[0] = ax0.tready;
  assign tr[1] = ax1.tready;

  datasink_ram #(.DATA_W(DW), .ADDR_W(AW), .THROTTLE(0)) dut0 (
    .clk(clk), .reset(reset), .s_axis(ax0.slave), .clear(clear), .rd_addr(ra),
    .rd_data(rd[0]), .done(dn[0]), .wr_count(cnt[0]), .checksum(cs[0]));

  datasink_ram #(.DATA_W(DW), .ADDR_W(AW), .THROTTLE(1)) dut1 (
    .clk(clk), .reset(reset), .s_axis(ax1.slave), .clear(clear), .rd_addr(ra),
    .rd_data(rd[1]), .done(dn[1]), .wr_count(cnt[1]), .checksum(cs[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Word-level model: a sink either idles one cycle, fills, or is full.
  typedef enum {M_IDLE, M_FILL, M_DONE} mst_t;
  int          th [2] = '{0, 1};
  mst_t        m_st [2];
  bit          m_ph [2];
  int          m_n [2];
  logic [31:0] m_sum [2];
  logic [31:0] m_mem [2][DEPTH];
  bit          m_wr [2][DEPTH];
  logic [31:0] m_rd [2];
  bit          m_rdk [2];

  function automatic bit m_ready(input int k);
    return (m_st[k] == M_FILL) && !clear && (th[k] == 0 || !m_ph[k]);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_ph[k] = 1'b0; m_n[k] = 0; m_sum[k] = '0;
      m_rd[k] = '0; m_rdk[k] = 1'b1;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      bit go;
      go = m_ready(k) && tv;
      m_rd[k]  = m_mem[k][ra];
      m_rdk[k] = m_wr[k][ra];
      if (clear) begin
        m_st[k] = M_IDLE; m_ph[k] = 1'b0; m_n[k] = 0; m_sum[k] = '0;
      end else if (m_st[k] == M_IDLE) begin
        m_st[k] = M_FILL; m_ph[k] = 1'b0;
      end else if (m_st[k] == M_FILL) begin
        if (go) begin
          m_mem[k][m_n[k] % DEPTH] = td;
          m_wr[k][m_n[k] % DEPTH]  = 1'b1;
          m_sum[k] = m_sum[k] + td;
          m_n[k]   = m_n[k] + 1;
          if (m_n[k] == DEPTH) m_st[k] = M_DONE;
        end
        m_ph[k] = !m_ph[k];
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tready%0d", k), tr[k], m_ready(k));
        chk($sformatf("done%0d", k), dn[k], m_st[k] == M_DONE);
        chk($sformatf("wr_count%0d", k), cnt[k], m_n[k]);
        chk($sformatf("checksum%0d", k), cs[k], m_sum[k]);
        if (m_rdk[k]) chk($sformatf("rd_data%0d", k), rd[k], m_rd[k]);
      end
    end
  end

  // Feeds 0x10+i, advancing i on each handshake of the unthrottled sink.
  task automatic stream0(input int n, input int gap_at, input int gap_len, output int cycles);
    int i;
    int g;
    i = 0; g = 0; cycles = 0;
    while (i < n && cycles < 60) begin
      @(negedge clk);
      if (i == gap_at && g < gap_len) begin tv = 1'b0; g++; end
      else tv = 1'b1;
      td = 32'h10 + i;
      #2;
      cycles++;
      if (!tv) chk("gap_count", cnt[0], gap_at);
      if (tv && tr[0]) i++;
    end
    if (i < n) chk("stream_timeout", i, n);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1; tv = 1'b0;
    @(negedge clk); clear = 1'b0;
  endtask

  initial begin
    int cyc;
    int fill;
    int acc;
    bit fin;

    repeat (2) @(negedge clk);
    #2;
    chk("rst_tready", tr[0], 1'b0);
    chk("rst_count", cnt[0], 0);
    chk("rst_sum", cs[0], 0);
    chk("rst_done", dn[0], 1'b0);
    chk("rst_rd", rd[0], 0);
    @(posedge clk); #1 reset = 1'b0;

    stream0(16, -1, 0, cyc);
    chk("t1_cycles", cyc, 17);
    @(negedge clk); tv = 1'b0; #2;
    chk("t1_done", dn[0], 1'b1);
    chk("t1_tready", tr[0], 1'b0);
    chk("t1_count", cnt[0], 16);
    chk("t1_sum", cs[0], 32'h178);

    ra = 4'd5;
    @(negedge clk); ra = 4'd15; #2;
    chk("rb_addr5", rd[0], 32'h15);
    @(negedge clk); #2;
    chk("rb_addr15", rd[0], 32'h1F);

    do_clear();
    stream0(16, 6, 3, cyc);
    @(negedge clk); tv = 1'b0; ra = '0; #2;
    chk("gap_sum", cs[0], 32'h178);
    chk("gap_cycles", cyc, 19);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      ra = AW'(a + 1);
      #2;
      chk($sformatf("gap_mem%0d", a), rd[0], 32'h10 + a);
    end

    @(negedge clk); clear = 1'b1; tv = 1'b1;
    @(negedge clk); clear = 1'b0;
    fill = 0; acc = 0; fin = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      td = $urandom;
      #2;
      if (dn[1]) begin fin = 1'b1; break; end
      if (fill == 0) chk("thr_first", tr[1], 1'b1);
      fill++;
      acc += int'(tr[1]);
    end
    chk("thr_finished", fin, 1'b1);
    chk("thr_cycles", fill, 31);
    chk("thr_accepts", acc, 16);

    @(negedge clk); clear = 1'b1; td = 32'hFFFF_FFFF;
    @(negedge clk); clear = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #2;
      if (dn[0] && dn[1]) begin fin = 1'b1; break; end
    end
    chk("wrap_finished", fin, 1'b1);
    chk("wrap_sum0", cs[0], 32'hFFFF_FFF0);
    chk("wrap_sum1", cs[1], 32'hFFFF_FFF0);
    @(negedge clk); tv = 1'b0; clear = 1'b1; #2;
    chk("clr_tready", tr[0], 1'b0);
    @(negedge clk); clear = 1'b0; ra = 4'd3; #2;
    chk("clr_done", dn[0], 1'b0);
    chk("clr_count", cnt[0], 0);
    chk("clr_sum", cs[0], 0);
    chk("clr_idle_tready", tr[0], 1'b0);
    @(negedge clk); #2;
    chk("clr_fill_tready", tr[0], 1'b1);
    chk("clr_keep_mem", rd[0], 32'hFFFF_FFFF);

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tv    = ($urandom % 4) != 0;
      td    = $urandom;
      ra    = AW'($urandom);
      clear = ($urandom % 40) == 0;
    end
    @(negedge clk); clear = 1'b0; tv = 1'b0;

    do_clear();
    stream0(7, -1, 0, cyc);
    @(negedge clk); tv = 1'b0;
    #3;
    chk("mid_count", cnt[0], 7);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", cnt[0], 0);
    chk("mid_rst_tready", tr[0], 1'b0);
    chk("mid_rst_done", dn[0], 1'b0);
    chk("mid_rst_sum", cs[0], 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); ra = 4'd6;
    @(negedge clk); #2;
    chk("mid_keep_mem", rd[0], 32'h16);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
